// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the regfile_mp multi-port register file:
// the clear-sequencer state enum, default geometry and the lane-priority select.
package regfile_mp_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    typedef enum logic [1:0] {
        LANE_NONE = 2'd0,
        LANE_0    = 2'd1,
        LANE_1    = 2'd2
    } lane_t;

    // Lane 1 is the younger retire lane, so it wins when both lanes hit.
    function automatic lane_t lane_select(input logic hit0, input logic hit1);
        if (hit1) begin
            return LANE_1;
        end
        if (hit0) begin
            return LANE_0;
        end
        return LANE_NONE;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the regfile_mp register file: two read ports,
// two write lanes and the bulk-clear request/busy pair.
interface regfile_mp_if
    import regfile_mp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = $clog2(DEF_DEPTH)
);
    logic [AW-1:0]    raddr1;
    logic [AW-1:0]    raddr2;
    logic [WIDTH-1:0] rdata1;
    logic [WIDTH-1:0] rdata2;
    logic [WIDTH-1:0] wdata0;
    logic [AW-1:0]    waddr0;
    logic             write0;
    logic [WIDTH-1:0] wdata1;
    logic [AW-1:0]    waddr1;
    logic             write1;
    logic             clear_req;
    logic             busy;

    modport master (
        output raddr1, raddr2, wdata0, waddr0, write0,
        output wdata1, waddr1, write1, clear_req,
        input  rdata1, rdata2, busy
    );

    modport slave (
        input  raddr1, raddr2, wdata0, waddr0, write0,
        input  wdata1, waddr1, write1, clear_req,
        output rdata1, rdata2, busy
    );

endinterface

// File: rtl/regfile_mp_clr_seq.sv
// Bulk-clear sequencer: walks every address once, one per cycle, holding busy
// for exactly DEPTH cycles. Requests while sweeping are ignored.
module regfile_mp_clr_seq
    import regfile_mp_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEF_DEPTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear_req,
    output logic          busy,
    output logic [AW-1:0] sweep_addr,
    output logic          sweep_we
);

    clr_state_t    state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (clear_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                if (cnt_reg == AW'(DEPTH - 1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy       = (state_reg == CLEAR);
    assign sweep_we   = (state_reg == CLEAR);
    assign sweep_addr = cnt_reg;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: 2 combinational read ports, 2 clocked write lanes,
// optional hardwired-zero reg 0 and a bulk clear. Macro REGFILE_MP_BYPASS_EN adds write-to-read forwarding.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    regfile_mp_if.slave rf
);

    localparam int AW = $clog2(DEPTH);

    logic          busy;
    logic          sweep_we;
    logic [AW-1:0] sweep_addr;

    regfile_mp_clr_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_seq (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_req  (rf.clear_req),
        .busy       (busy),
        .sweep_addr (sweep_addr),
        .sweep_we   (sweep_we)
    );

    assign rf.busy = busy;

    // A lane is live only outside a sweep and never for a hardwired-zero reg 0.
    logic wr_ok0, wr_ok1;
    assign wr_ok0 = rf.write0 && !busy && !(ZERO_REG && (rf.waddr0 == '0));
    assign wr_ok1 = rf.write1 && !busy && !(ZERO_REG && (rf.waddr1 == '0));

    logic [WIDTH-1:0] mem [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [WIDTH-1:0] word_reg, word_next;
            logic             hit0, hit1;

            assign hit0 = wr_ok0 && (rf.waddr0 == AW'(gi));
            assign hit1 = wr_ok1 && (rf.waddr1 == AW'(gi));

            always_comb begin
                word_next = word_reg;
                if (sweep_we) begin
                    if (sweep_addr == AW'(gi)) begin
                        word_next = '0;
                    end
                end else begin
                    case (lane_select(hit0, hit1))
                        LANE_1:  word_next = rf.wdata1;
                        LANE_0:  word_next = rf.wdata0;
                        default: word_next = word_reg;
                    endcase
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    word_reg <= '0;
                end else begin
                    word_reg <= word_next;
                end
            end

            assign mem[gi] = word_reg;
        end
    endgenerate

    logic [AW-1:0]    raddr [2];
    logic [WIDTH-1:0] rdata [2];

    assign raddr[0]  = rf.raddr1;
    assign raddr[1]  = rf.raddr2;
    assign rf.rdata1 = rdata[0];
    assign rf.rdata2 = rdata[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rport
            logic [WIDTH-1:0] rd_val;
`ifdef REGFILE_MP_BYPASS_EN
            logic fwd0, fwd1;
            assign fwd0 = wr_ok0 && (rf.waddr0 == raddr[gi]);
            assign fwd1 = wr_ok1 && (rf.waddr1 == raddr[gi]);
`endif

            always_comb begin
                rd_val = mem[raddr[gi]];
`ifdef REGFILE_MP_BYPASS_EN
                case (lane_select(fwd0, fwd1))
                    LANE_1:  rd_val = rf.wdata1;
                    LANE_0:  rd_val = rf.wdata0;
                    default: rd_val = mem[raddr[gi]];
                endcase
`endif
                if (ZERO_REG && (raddr[gi] == '0)) begin
                    rd_val = '0;
                end
            end

            assign rdata[gi] = rd_val;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: one plain instance and one ZERO_REG=1
// instance share stimulus and are checked against a behavioural model.
module tb_regfile_mp;

    logic clock;
    logic reset_n;

    regfile_mp_if #(.WIDTH(16), .AW(3)) bus_a ();
    regfile_mp_if #(.WIDTH(16), .AW(3)) bus_z ();

    assign bus_z.raddr1    = bus_a.raddr1;
    assign bus_z.raddr2    = bus_a.raddr2;
    assign bus_z.wdata0    = bus_a.wdata0;
    assign bus_z.waddr0    = bus_a.waddr0;
    assign bus_z.write0    = bus_a.write0;
    assign bus_z.wdata1    = bus_a.wdata1;
    assign bus_z.waddr1    = bus_a.waddr1;
    assign bus_z.write1    = bus_a.write1;
    assign bus_z.clear_req = bus_a.clear_req;

    regfile_mp #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b0)) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .rf      (bus_a)
    );

    regfile_mp #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b1)) dut_z (
        .clock   (clock),
        .reset_n (reset_n),
        .rf      (bus_z)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Reference: index 0 = plain instance, index 1 = hardwired-zero instance.
    logic [15:0] m [2][8];
    int sweep_left;
    int sweep_pos;
    int errors;
    int checks;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_read(input int z, input logic [2:0] a);
        if (z == 1 && a == 3'd0) return 16'h0000;
        if (BYP && sweep_left == 0) begin
            if (bus_a.write1 && bus_a.waddr1 == a) return bus_a.wdata1;
            if (bus_a.write0 && bus_a.waddr0 == a) return bus_a.wdata0;
        end
        return m[z][a];
    endfunction

    task automatic model_reset();
        for (int z = 0; z < 2; z++)
            for (int a = 0; a < 8; a++) m[z][a] = 16'h0000;
        sweep_left = 0;
        sweep_pos  = 0;
    endtask

    task automatic check_ports(input string tag);
        chk({tag, ".a.r1"}, bus_a.rdata1, exp_read(0, bus_a.raddr1));
        chk({tag, ".a.r2"}, bus_a.rdata2, exp_read(0, bus_a.raddr2));
        chk({tag, ".z.r1"}, bus_z.rdata1, exp_read(1, bus_a.raddr1));
        chk({tag, ".z.r2"}, bus_z.rdata2, exp_read(1, bus_a.raddr2));
        chk({tag, ".a.busy"}, bus_a.busy, sweep_left > 0);
        chk({tag, ".z.busy"}, bus_z.busy, sweep_left > 0);
    endtask

    task automatic check_all(input string tag);
        for (int a = 0; a < 8; a++) begin
            bus_a.raddr1 = 3'(a);
            bus_a.raddr2 = 3'(7 - a);
            #1;
            check_ports(tag);
        end
    endtask

    // Advance one clock edge, applying the architectural rules to the model.
    task automatic tick();
        logic [15:0] nxt [2][8];
        int nl, np;
        nxt = m;
        nl  = sweep_left;
        np  = sweep_pos;
        if (sweep_left > 0) begin
            for (int z = 0; z < 2; z++) nxt[z][sweep_pos] = 16'h0000;
            np = sweep_pos + 1;
            nl = sweep_left - 1;
        end else begin
            for (int z = 0; z < 2; z++) begin
                if (bus_a.write0 && !(z == 1 && bus_a.waddr0 == 3'd0)) nxt[z][bus_a.waddr0] = bus_a.wdata0;
                if (bus_a.write1 && !(z == 1 && bus_a.waddr1 == 3'd0)) nxt[z][bus_a.waddr1] = bus_a.wdata1;
            end
            if (bus_a.clear_req) begin
                nl = 8;
                np = 0;
            end
        end
        $display("tick t=%0t w0=%b a0=%0d d0=%h w1=%b a1=%0d d1=%h clr=%b busy=%b",
                 $time, bus_a.write0, bus_a.waddr0, bus_a.wdata0,
                 bus_a.write1, bus_a.waddr1, bus_a.wdata1, bus_a.clear_req, bus_a.busy);
        @(posedge clock);
        m          = nxt;
        sweep_left = nl;
        sweep_pos  = np;
        #1;
    endtask

    task automatic idle_inputs();
        bus_a.write0    = 1'b0;
        bus_a.write1    = 1'b0;
        bus_a.clear_req = 1'b0;
        bus_a.waddr0    = 3'd0;
        bus_a.waddr1    = 3'd0;
        bus_a.wdata0    = 16'h0000;
        bus_a.wdata1    = 16'h0000;
    endtask

    initial begin
        int n;
        errors  = 0;
        checks  = 0;
        reset_n = 1'b0;
        idle_inputs();
        bus_a.raddr1 = 3'd0;
        bus_a.raddr2 = 3'd0;
        model_reset();

        // Power-on reset
        #3;
        check_all("por");
        #2 reset_n = 1'b1;
        tick();

        // Preload random contents, then reset asynchronously mid-cycle
        for (int k = 0; k < 4; k++) begin
            bus_a.write0 = 1'b1; bus_a.waddr0 = 3'(2 * k);     bus_a.wdata0 = 16'($urandom);
            bus_a.write1 = 1'b1; bus_a.waddr1 = 3'(2 * k + 1); bus_a.wdata1 = 16'($urandom);
            tick();
        end
        idle_inputs();
        check_all("preload");
        tick();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check_all("reset_preloaded");
        reset_n = 1'b1;
        tick();

        // Single write: old value in the write cycle (new with forwarding), new after
        bus_a.write0 = 1'b1; bus_a.waddr0 = 3'd1; bus_a.wdata0 = 16'd9;
        bus_a.raddr2 = 3'd1;
        #1;
        chk("same_cycle_r2", bus_a.rdata2, BYP ? 32'd9 : 32'd0);
        tick();
        idle_inputs();
        #1;
        chk("after_edge_r2", bus_a.rdata2, 32'd9);

        // Lane collision and independent lanes
        bus_a.write0 = 1'b1; bus_a.waddr0 = 3'd6; bus_a.wdata0 = 16'd7;
        bus_a.write1 = 1'b1; bus_a.waddr1 = 3'd6; bus_a.wdata1 = 16'd5;
        tick();
        bus_a.waddr0 = 3'd3; bus_a.wdata0 = 16'hAAAA;
        bus_a.waddr1 = 3'd4; bus_a.wdata1 = 16'h5555;
        tick();
        idle_inputs();
        bus_a.raddr1 = 3'd6; bus_a.raddr2 = 3'd3;
        #1;
        chk("collide_lane1", bus_a.rdata1, 32'h5);
        chk("lane0_r3", bus_a.rdata2, 32'hAAAA);
        bus_a.raddr1 = 3'd4;
        #1;
        chk("lane1_r4", bus_a.rdata1, 32'h5555);
        check_all("lanes");

        // Hardwired-zero register 0
        bus_a.write0 = 1'b1; bus_a.waddr0 = 3'd0; bus_a.wdata0 = 16'hFFFF;
        bus_a.write1 = 1'b1; bus_a.waddr1 = 3'd1; bus_a.wdata1 = 16'h1234;
        bus_a.raddr1 = 3'd0;
        #1;
        chk("zero_bypass_r0", bus_z.rdata1, 32'h0);
        tick();
        idle_inputs();
        bus_a.raddr1 = 3'd0; bus_a.raddr2 = 3'd1;
        #1;
        chk("zero_r0", bus_z.rdata1, 32'h0);
        chk("zero_r1", bus_z.rdata2, 32'h1234);
        chk("plain_r0", bus_a.rdata1, 32'hFFFF);
        check_all("zero_reg");

        // Randomized traffic with occasional clear requests
        for (int k = 0; k < 60; k++) begin
            bus_a.write0    = 1'($urandom);
            bus_a.waddr0    = 3'($urandom);
            bus_a.wdata0    = 16'($urandom);
            bus_a.write1    = 1'($urandom);
            bus_a.waddr1    = 3'($urandom_range(0, 3) == 0 ? bus_a.waddr0 : 3'($urandom));
            bus_a.wdata1    = 16'($urandom);
            bus_a.clear_req = ($urandom_range(0, 19) == 0);
            bus_a.raddr1    = 3'($urandom_range(0, 1) == 0 ? bus_a.waddr0 : 3'($urandom));
            bus_a.raddr2    = 3'($urandom_range(0, 1) == 0 ? bus_a.waddr1 : 3'($urandom));
            #1;
            check_ports("rand");
            tick();
        end
        idle_inputs();
        n = 0;
        while (bus_a.busy && n < 20) begin
            n++;
            tick();
        end
        chk("rand_idle", bus_a.busy, 32'd0);
        check_all("rand_end");

        // Fill 0x0011*i then sweep; writes and restarts during the sweep are ignored
        for (int k = 0; k < 4; k++) begin
            bus_a.write0 = 1'b1; bus_a.waddr0 = 3'(2 * k);     bus_a.wdata0 = 16'(17 * (2 * k));
            bus_a.write1 = 1'b1; bus_a.waddr1 = 3'(2 * k + 1); bus_a.wdata1 = 16'(17 * (2 * k + 1));
            tick();
        end
        idle_inputs();
        check_all("fill");
        bus_a.clear_req = 1'b1;
        tick();
        bus_a.clear_req = 1'b0;
        bus_a.write0 = 1'b1; bus_a.waddr0 = 3'd7; bus_a.wdata0 = 16'hBEEF;
        n = 0;
        while (bus_a.busy && n < 20) begin
            n++;
            if (n == 4) begin
                bus_a.raddr1 = 3'd2; bus_a.raddr2 = 3'd5;
                #1;
                chk("sweep3_r2", bus_a.rdata1, 32'h0);
                chk("sweep3_r5", bus_a.rdata2, 32'h55);
                check_all("sweep3");
            end
            bus_a.clear_req = (n == 5);
            tick();
        end
        idle_inputs();
        chk("busy_cycles", n, 32'd8);
        bus_a.raddr1 = 3'd7;
        #1;
        chk("sweep_r7", bus_a.rdata1, 32'h0);
        check_all("swept");

        // Reset during the sweep abandons it
        bus_a.write0 = 1'b1; bus_a.waddr0 = 3'd5; bus_a.wdata0 = 16'h0123;
        tick();
        bus_a.clear_req = 1'b1;
        tick();
        idle_inputs();
        tick(); tick(); tick();
        #4 reset_n = 1'b0;
        model_reset();
        #1;
        chk("midclr_busy", bus_a.busy, 32'd0);
        check_all("midclr_reset");
        reset_n = 1'b1;
        bus_a.write0 = 1'b1; bus_a.waddr0 = 3'd2; bus_a.wdata0 = 16'd9;
        tick();
        idle_inputs();
        for (int k = 0; k < 10; k++) begin
            bus_a.raddr1 = 3'd2;
            bus_a.raddr2 = 3'(k % 8);
            #1;
            chk("post_reset_r2", bus_a.rdata1, 32'd9);
            check_ports("post_reset");
            tick();
        end
        check_all("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; next generation of the 8 x 16 RegFile used by the processor datapath.
- Provides 2 combinational read ports and 2 clocked write ports.
- Adds asynchronous reset, an optional hardwired-zero register 0, and a sequenced bulk-clear engine with a busy flag.
- Sits between decode (read addresses) and writeback (two retire lanes).

Parameters:
- WIDTH, 16: data width in bits.
- DEPTH, 8: number of registers; power of two, at least 2.
- ZERO_REG, 0: when 1, register 0 always reads 0 and writes to it are discarded.
- Localparam AW = $clog2(DEPTH): address width.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- rdata1  out  WIDTH  read data for raddr1.
- rdata2  out  WIDTH  read data for raddr2.
- raddr1  in  AW  read address 1.
- raddr2  in  AW  read address 2.
- wdata0  in  WIDTH  write data, lane 0.
- waddr0  in  AW  write address, lane 0.
- write0  in  1  write enable, lane 0.
- wdata1  in  WIDTH  write data, lane 1.
- waddr1  in  AW  write address, lane 1.
- write1  in  1  write enable, lane 1.
- clear_req  in  1  single-cycle pulse; starts a bulk clear.
- busy  out  1  high while a bulk clear is in progress.

Behaviour:
- One clock; reset is asynchronous and active-low. Port names are clock and reset_n.
- Reset (reset_n=0, immediate): all registers 0, FSM to IDLE, sweep counter 0, busy=0. rdata1 and rdata2 therefore read 0.
- Reads are combinational from the stored array, with zero latency.
- Writes commit on the rising clock edge when the enable is high.
  - A write is visible on the read ports after that edge.
  - Without bypass, a read in the same cycle as the write returns the old value.
- Simultaneous writes to the same address from both lanes: lane 1 wins.
- Writes to different addresses: both commit.
- ZERO_REG=1:
  - Writes with address 0 are dropped.
  - A read of address 0 returns 0, including under bypass.
  - The clear sweep still visits address 0 (harmless).
- FSM states: IDLE, CLEAR.
  - IDLE, clear_req=1: go to CLEAR on the next edge, counter=0, busy=1 from that edge.
  - CLEAR, each cycle: reg[counter] is set to 0 on the edge and counter increments.
  - CLEAR, counter==DEPTH-1: that register is cleared and the FSM returns to IDLE on the same edge. busy falls, counter resets to 0.
  - Total busy duration: exactly DEPTH cycles.
- During CLEAR:
  - write0 and write1 are ignored; no register changes except the sweep target.
  - clear_req is ignored; no restart and no extension.
  - Reads return current contents: already-swept registers read 0, unswept registers keep their old value.
- clear_req coinciding with writes in IDLE: the writes commit on that edge, then the sweep starts and clears them.
- reset_n asserted mid-clear: immediate full reset as above. The sweep is abandoned and does not resume.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined:
  - Write-to-read forwarding. If a read address equals an enabled write address in the same cycle, the read port returns that write data combinationally.
  - Lane 1 data takes priority over lane 0.
  - Forwarding is suppressed while busy=1, and for address 0 when ZERO_REG=1.
- Undefined: reads always return stored contents; no forwarding logic is built.

Decomposition:
- Package regfile_mp_pkg holds:
  - the FSM state enum (IDLE, CLEAR);
  - the default WIDTH and DEPTH constants;
  - a function for the lane-priority select used by the write and bypass paths.
- One natural sub-module: regfile_mp_clr_seq. It holds the IDLE/CLEAR FSM and sweep counter, and outputs busy, the sweep address and a sweep write strobe.
- The top level holds the array, the write merge and the read muxes.

Test Plan:
- Reset with array preloaded via writes: reset_n=0 -> rdata1/rdata2 read 0 for all 8 addresses; busy=0.
- write0=1, waddr0=1, wdata0=9, one edge; raddr2=1 -> rdata2=9 after the edge and old value 0 before it (no bypass). With REGFILE_MP_BYPASS_EN, rdata2=9 in the same cycle.
- Both lanes write address 6, wdata0=7 and wdata1=5 -> reg[6]=5. Lanes write 3 and 4 with 0xAAAA and 0x5555 -> both stored.
- ZERO_REG=1, write address 0 with 0xFFFF -> rdata1 at raddr1=0 stays 0; reg 1 unaffected.
- Fill regs 0..7 with 0x0011*i, pulse clear_req:
  - busy high exactly 8 cycles;
  - at cycle 3 of the sweep, regs 0..2 read 0 and reg 5 reads 0x0055;
  - write0 to reg 7 during the sweep is ignored;
  - after the sweep all regs read 0.
- Pulse clear_req, assert reset_n=0 at sweep cycle 4 -> busy=0 immediately and all regs 0. After release, a write of 9 to reg 2 commits normally and no sweep activity resumes.
